// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Used by serial_add_ctrl; the optional subtract path is selected by
// the SERIAL_ADD_SUB_EN macro inside serial_add_ctrl.
package serial_add_pkg;

    // Default operand/result width in bits (legal range 2..32).
    localparam int WIDTH_DEFAULT = 8;

    // Controller states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit counter width. The extra bit keeps cnt from wrapping at WIDTH-1
    // even when WIDTH is a power of two.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational single-bit full adder. The serial controller instantiates
// exactly one of these and sequences it over the operand bits.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first
// through a single fa_cell, one bit per clock, with a start/busy/done
// handshake.
//
// Optional feature: define SERIAL_ADD_SUB_EN to add the Sub port. With
// Sub=1 the B bits are inverted into the cell and the carry starts at 1,
// giving A - B; Cout=1 then means no borrow.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one operand bit per cycle through fa_cell, LSB first
// DONE  | one-cycle result strobe; Sum/Cout already hold the new result
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             running;
    logic             last_bit;

    logic             cell_b;
    logic             cell_sum;
    logic             cell_cout;

    logic             carry_init;

`ifdef SERIAL_ADD_SUB_EN
    logic             sub_r;
`endif

    assign accept   = (state == IDLE) && start;
    assign running  = (state == RUN);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Cell operand selection: B is inverted for subtraction, and the
    // initial carry becomes 1 so the cell computes A + ~B + 1.
`ifdef SERIAL_ADD_SUB_EN
    assign cell_b     = b_sr[0] ^ sub_r;
    assign carry_init = Sub ? 1'b1 : Cin;
`else
    assign cell_b     = b_sr[0];
    assign carry_init = Cin;
`endif

    fa_cell u_fa_cell (
        .a    (a_sr[0]),
        .b    (cell_b),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; busy and done are decoded from the state alone so
    // no input reaches an output combinationally.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one right shift per RUN cycle with
    // the cell's sum bit entering the MSB of the result shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sr  <= A;
            b_sr  <= B;
            s_sr  <= '0;
            carry <= carry_init;
            cnt   <= '0;
        end else if (running) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            s_sr  <= {cell_sum, s_sr[WIDTH-1:1]};
            carry <= cell_cout;
            cnt   <= cnt + CW'(1);
        end
    end

`ifdef SERIAL_ADD_SUB_EN
    // Subtract select is latched with the operands so later changes on
    // Sub cannot disturb an operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_r <= 1'b0;
        end else if (accept) begin
            sub_r <= Sub;
        end
    end
`endif

    // Result registers load only on the final RUN edge, taking the last
    // sum bit and carry straight from the cell; a reset mid-operation
    // clears them and the aborted result never appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else if (running && last_bit) begin
            Sum  <= {cell_sum, s_sr[WIDTH-1:1]};
            Cout <= cell_cout;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an 8-bit instance for the
// directed, random, handshake and reset scenarios, plus a 4-bit instance
// swept over every A/B/Cin combination.
module tb_serial_add_ctrl;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic          clk;
    logic          rst_n;

    logic          start8;
    logic [W8-1:0] a8;
    logic [W8-1:0] b8;
    logic          cin8;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] sum8;
    logic          cout8;

    logic          start4;
    logic [W4-1:0] a4;
    logic [W4-1:0] b4;
    logic          cin4;
    logic          busy4;
    logic          done4;
    logic [W4-1:0] sum4;
    logic          cout4;

`ifdef SERIAL_ADD_SUB_EN
    logic          sub8;
    logic          sub4;
`endif

    int n_vec;
    int n_err;
    int n_done4;

    serial_add_ctrl #(.WIDTH(W8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Cin   (cin8),
`ifdef SERIAL_ADD_SUB_EN
        .Sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .Sum   (sum8),
        .Cout  (cout8)
    );

    serial_add_ctrl #(.WIDTH(W4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .A     (a4),
        .B     (b4),
        .Cin   (cin4),
`ifdef SERIAL_ADD_SUB_EN
        .Sub   (sub4),
`endif
        .busy  (busy4),
        .done  (done4),
        .Sum   (sum4),
        .Cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && done4) n_done4++;
    end

    // Runs one 8-bit operation from an idle negedge. lat counts cycles
    // from the accepting edge until done is seen; busy_n counts busy
    // cycles up to and including the done cycle.
    task automatic do_op8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic c,
                          output logic [W8-1:0] s, output logic co, output int lat,
                          output int busy_n, output logic tail_busy, output logic tail_done,
                          output logic timeout);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = 0; busy_n = 0; timeout = 1'b0;
        while (!done8 && lat < 64) begin
            if (busy8) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (!done8) timeout = 1'b1;
        if (busy8) busy_n++;
        s  = sum8;
        co = cout8;
        @(negedge clk);
        tail_busy = busy8;
        tail_done = done8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub8 = 1'b0; sub4 = 1'b0;
`endif
        #12;
        n_vec++;
        if ({busy8, done8, sum8, cout8} !== 11'b0) begin
            n_err++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
        end
        n_vec++;
        if ({busy4, done4, sum4, cout4} !== 7'b0) begin
            n_err++;
            $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b, want all 0", busy4, done4, sum4, cout4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W8-1:0] s;
        logic          co, tb, td, to;
        int            lat, bn;
        logic [W8-1:0] va [3];
        logic [W8-1:0] vb [3];
        logic          vc [3];
        logic [W8:0]   exp;
        va[0] = 8'h5A; vb[0] = 8'h33; vc[0] = 1'b0;
        va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0;
        va[2] = 8'hFF; vb[2] = 8'h00; vc[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op8(va[i], vb[i], vc[i], s, co, lat, bn, tb, td, to);
            exp = {1'b0, va[i]} + {1'b0, vb[i]} + {8'b0, vc[i]};
            n_vec++;
            if (to !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d timeout: no done within 64 cycles", i);
            end
            n_vec++;
            if ({co, s} !== exp) begin
                n_err++;
                $display("FAIL directed%0d result: got cout=%b sum=%h, want cout=%b sum=%h", i, co, s, exp[W8], exp[W8-1:0]);
            end
            n_vec++;
            if (lat !== W8) begin
                n_err++;
                $display("FAIL directed%0d latency: got %0d, want %0d", i, lat, W8);
            end
            n_vec++;
            if (bn !== W8 + 1) begin
                n_err++;
                $display("FAIL directed%0d busy_cycles: got %0d, want %0d", i, bn, W8 + 1);
            end
            n_vec++;
            if ({tb, td} !== 2'b00) begin
                n_err++;
                $display("FAIL directed%0d after_done: got busy=%b done=%b, want 0 0", i, tb, td);
            end
            n_vec++;
            if ({cout8, sum8} !== exp) begin
                n_err++;
                $display("FAIL directed%0d held: got cout=%b sum=%h, want cout=%b sum=%h", i, cout8, sum8, exp[W8], exp[W8-1:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [W8-1:0] a, b, s;
        logic          c, co, tb, td, to;
        int            lat, bn;
        logic [W8:0]   exp;
        for (int i = 0; i < 40; i++) begin
            a = W8'($urandom);
            b = W8'($urandom);
            c = 1'($urandom);
            do_op8(a, b, c, s, co, lat, bn, tb, td, to);
            exp = {1'b0, a} + {1'b0, b} + {8'b0, c};
            n_vec++;
            if (to !== 1'b0 || {co, s} !== exp) begin
                n_err++;
                $display("FAIL random%0d: a=%h b=%h c=%b got cout=%b sum=%h, want cout=%b sum=%h", i, a, b, c, co, s, exp[W8], exp[W8-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   accepts[$];
        int   dones;
        logic prev_busy;
        int   guard;
        dones = 0;
        prev_busy = busy8;
        start8 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a8 = W8'($urandom);
            if (busy8 && !prev_busy) accepts.push_back(i);
            if (done8) dones++;
            prev_busy = busy8;
        end
        start8 = 1'b0;
        guard = 0;
        while (busy8 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (accepts.size() !== 3) begin
            n_err++;
            $display("FAIL b2b accept_count: got %0d, want 3", accepts.size());
        end
        for (int k = 1; k < accepts.size(); k++) begin
            n_vec++;
            if (accepts[k] - accepts[k-1] !== W8 + 2) begin
                n_err++;
                $display("FAIL b2b spacing%0d: got %0d, want %0d", k, accepts[k] - accepts[k-1], W8 + 2);
            end
        end
        n_vec++;
        if (dones !== 3) begin
            n_err++;
            $display("FAIL b2b done_count: got %0d, want 3", dones);
        end
        n_vec++;
        if (busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b settle: busy still %b", busy8);
        end
    endtask

    task automatic test_capture();
        int          guard;
        logic [W8:0] exp;
        exp = 9'h12 + 9'h34 + 9'h1;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = W8'($urandom); b8 = W8'($urandom); cin8 = ~cin8;
            @(negedge clk);
        end
        guard = 0;
        while (!done8 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (done8 !== 1'b1 || {cout8, sum8} !== exp) begin
            n_err++;
            $display("FAIL capture: got done=%b cout=%b sum=%h, want done=1 cout=%b sum=%h", done8, cout8, sum8, exp[W8], exp[W8-1:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [W8-1:0] s;
        logic          co, tb, td, to;
        int            lat, bn, stray;
        logic [W8:0]   exp;
        do_op8(8'hC3, 8'h5A, 1'b1, s, co, lat, bn, tb, td, to);
        n_vec++;
        if ({co, s} !== 9'h11E) begin
            n_err++;
            $display("FAIL abort_pre: got cout=%b sum=%h, want cout=1 sum=1e", co, s);
        end
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy8, done8, sum8, cout8} !== 11'b0) begin
            n_err++;
            $display("FAIL abort_clear: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) stray++;
        end
        n_vec++;
        if (stray !== 0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_quiet: got stray=%0d sum=%h cout=%b, want 0 00 0", stray, sum8, cout8);
        end
        do_op8(8'hA7, 8'h6C, 1'b0, s, co, lat, bn, tb, td, to);
        exp = 9'hA7 + 9'h6C;
        n_vec++;
        if (to !== 1'b0 || {co, s} !== exp || lat !== W8) begin
            n_err++;
            $display("FAIL abort_recover: got cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=%0d", co, s, lat, exp[W8], exp[W8-1:0], W8);
        end
    endtask

    task automatic test_exhaustive_w4();
        int          done_base;
        int          guard;
        int          bad;
        logic [W4:0] exp;
        logic [8:0]  idx;
        done_base = n_done4;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            idx = 9'(i);
            @(negedge clk);
            a4 = idx[3:0]; b4 = idx[7:4]; cin4 = idx[8]; start4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start4 = 1'b0;
            guard = 0;
            while (!done4 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            exp = {1'b0, idx[3:0]} + {1'b0, idx[7:4]} + {4'b0, idx[8]};
            n_vec++;
            if (done4 !== 1'b1 || {cout4, sum4} !== exp) begin
                n_err++;
                bad++;
                if (bad <= 8)
                    $display("FAIL w4 a=%h b=%h c=%b: got done=%b cout=%b sum=%h, want cout=%b sum=%h",
                             idx[3:0], idx[7:4], idx[8], done4, cout4, sum4, exp[W4], exp[W4-1:0]);
            end
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (n_done4 - done_base !== 512) begin
            n_err++;
            $display("FAIL w4 done_count: got %0d, want 512", n_done4 - done_base);
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        logic [W8-1:0] s;
        logic          co, tb, td, to;
        int            lat, bn;
        logic [W8-1:0] va [2];
        logic [W8-1:0] vb [2];
        logic [W8:0]   exp;
        va[0] = 8'h10; vb[0] = 8'h01;
        va[1] = 8'h00; vb[1] = 8'h01;
        for (int i = 0; i < 2; i++) begin
            sub8 = 1'b1;
            do_op8(va[i], vb[i], 1'b0, s, co, lat, bn, tb, td, to);
            sub8 = 1'b0;
            exp = {1'b0, va[i]} + {1'b0, ~vb[i]} + 9'd1;
            n_vec++;
            if (to !== 1'b0 || {co, s} !== exp) begin
                n_err++;
                $display("FAIL sub%0d: got cout=%b sum=%h, want cout=%b sum=%h", i, co, s, exp[W8], exp[W8-1:0]);
            end
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        n_done4 = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_capture();
        test_reset_mid_run();
        test_exhaustive_w4();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
